// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: controller state encoding, width helpers
// and handshake latencies used by the multiplier/divider controller.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } arith_state_e;

  function automatic int op_w(input int size);
    return 1 << size;
  endfunction

  function automatic int prod_w(input int size);
    return 2 << size;
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int div_latency(input int size);
    return (1 << size) + 2;
  endfunction

  localparam int DEFAULT_SIZE   = 3;
  localparam int DEFAULT_W      = 1 << DEFAULT_SIZE;
  localparam int DEFAULT_PROD_W = 2 * DEFAULT_W;
  localparam int DIV_LATENCY    = DEFAULT_W + 2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, keep or restore.
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0] p,
  input  logic       q_msb,
  input  logic [W:0] d,
  output logic [W:0] p_next,
  output logic       q_bit
);

  logic [W+1:0] shifted;

  always_comb begin
    shifted = {p, q_msb};
    q_bit   = (shifted >= {1'b0, d});
    p_next  = q_bit ? (shifted[W:0] - d) : shifted[W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, 2W-bit dividend by W-bit divisor, one quotient
// bit per clock; start/done handshake shared with the Booth multiplier.
module seq_divider
  import arith_pkg::*;
#(
  parameter int size = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic signed [prod_w(size)-1:0]  dividend,
  input  logic signed [op_w(size)-1:0]    divisor,
  output logic signed [op_w(size)-1:0]    quotient,
  output logic signed [op_w(size)-1:0]    remainder,
  output logic                            done,
  output logic                            busy,
  output logic                            dbz,
  output logic                            ovf
);

  localparam int W  = op_w(size);
  localparam int W2 = prod_w(size);
  localparam logic [W-1:0] Q_MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MAX_NEG = {1'b1, {(W-1){1'b0}}};

  // Extra top bit lets the most negative value produce its true magnitude.
  function automatic logic [W2:0] mag_dvd(input logic signed [W2-1:0] v);
    logic [W2:0] e;
    e = {v[W2-1], v};
    return v[W2-1] ? -e : e;
  endfunction

  function automatic logic [W:0] mag_dvs(input logic signed [W-1:0] v);
    logic [W:0] e;
    e = {v[W-1], v};
    return v[W-1] ? -e : e;
  endfunction

  arith_state_e state, state_nxt;

  logic signed [W2-1:0] dvd_r;
  logic signed [W-1:0]  dvs_r;
  logic                 sign_dvd, sign_q, dbz_r, uovf_r;
  logic [W:0]           dvs_mag, p, p_next;
  logic [W-1:0]         qs;
  logic [size-1:0]      cnt;
  logic                 q_bit;

  logic [W2:0]          dvd_mag;
  logic [W:0]           dvs_mag_c;
  logic [W-1:0]         q_apply, r_apply;
  logic                 ovf_c;

  div_step #(.W(W)) u_step (
    .p      (p),
    .q_msb  (qs[W-1]),
    .d      (dvs_mag),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_comb begin
    dvd_mag   = mag_dvd(dvd_r);
    dvs_mag_c = mag_dvs(dvs_r);
    q_apply   = sign_q ? -qs : qs;
    r_apply   = sign_dvd ? -p[W-1:0] : p[W-1:0];
    ovf_c     = !dbz_r && (uovf_r || (!sign_q && (qs > Q_MAX_POS)) ||
                                     (sign_q && (qs > Q_MAX_NEG)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      sign_dvd  <= 1'b0;
      sign_q    <= 1'b0;
      dbz_r     <= 1'b0;
      uovf_r    <= 1'b0;
      dvs_mag   <= '0;
      p         <= '0;
      qs        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          sign_dvd <= dvd_r[W2-1];
          sign_q   <= dvd_r[W2-1] ^ dvs_r[W-1];
          dvs_mag  <= dvs_mag_c;
          p        <= dvd_mag[W2:W];
          qs       <= dvd_mag[W-1:0];
          dbz_r    <= (dvs_r == '0);
          uovf_r   <= (dvd_mag[W2:W] >= dvs_mag_c);
          cnt      <= {size{1'b1}};
        end
        DIV: begin
          p   <= p_next;
          qs  <= {qs[W-2:0], q_bit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dbz_r) begin
            quotient  <= '1;
            remainder <= dvd_r[W-1:0];
            dbz       <= 1'b1;
            ovf       <= 1'b0;
          end else if (ovf_c) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= q_apply;
            remainder <= r_apply;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (W=8): integer-arithmetic reference model with a
// per-cycle compare process, plus directed literal cases and random operations.
module tb_seq_divider;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] dividend = '0;
  logic signed [7:0]  divisor = '0;
  logic [7:0]         quotient, remainder;
  logic               done, busy, dbz, ovf;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  seq_divider #(.size(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } res_t;

  function automatic res_t model(input logic signed [15:0] a, input logic signed [7:0] b);
    res_t   res;
    longint qa, ra;
    res = '0;
    if (b == 0) begin
      res.q   = 8'hFF;
      res.r   = a[7:0];
      res.dbz = 1'b1;
    end else begin
      qa = longint'(a) / longint'(b);
      ra = longint'(a) % longint'(b);
      if (qa > 127 || qa < -128) res.ovf = 1'b1;
      else begin
        res.q = qa[7:0];
        res.r = ra[7:0];
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted operation completes 10 edges later; start is only
  // seen while no operation is outstanding.
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  int   m_left   = 0;
  res_t m_res    = '0;
  res_t m_pend   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_left   <= 0;
      m_res    <= '0;
      m_pend   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_res    <= m_pend;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_left   <= 10;
        m_pend   <= model(dividend, divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_res.q));
      chk("remainder", 32'(remainder), 32'(m_res.r));
      chk("dbz", 32'(dbz), 32'(m_res.dbz));
      chk("ovf", 32'(ovf), 32'(m_res.ovf));
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a falling edge; start is presented for exactly one rising edge.
  task automatic launch(input logic signed [15:0] a, input logic signed [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic directed(input string name, input logic signed [15:0] a,
                          input logic signed [7:0] b, input logic [7:0] eq,
                          input logic [7:0] er, input logic edbz, input logic eovf);
    int lat;
    launch(a, b);
    wait_done(lat);
    chk({name, " latency"}, 32'(lat), 32'd10);
    chk({name, " quotient"}, 32'(quotient), 32'(eq));
    chk({name, " remainder"}, 32'(remainder), 32'(er));
    chk({name, " dbz"}, 32'(dbz), 32'(edbz));
    chk({name, " ovf"}, 32'(ovf), 32'(eovf));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, seen, mode, bi, qi, ri;
    logic signed [15:0] a;
    logic signed [7:0]  b;

    repeat (3) @(negedge clk);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset flags", 32'({done, busy, dbz, ovf}), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    directed("100/7", 16'sd100, 8'sd7, 8'd14, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    directed("-100/7", -16'sd100, 8'sd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    directed("100/-7", 16'sd100, -8'sd7, 8'hF2, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    directed("-128/1", -16'sd128, 8'sd1, 8'h80, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    directed("128/-1", 16'sd128, -8'sd1, 8'h80, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    directed("128/1", 16'sd128, 8'sd1, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    directed("7F00/1", 16'sh7F00, 8'sd1, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    directed("1234/0", 16'sd1234, 8'sd0, 8'hFF, 8'hD2, 1'b1, 1'b0);
    @(negedge clk);
    directed("0/5", 16'sd0, 8'sd5, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    directed("-32768/-1", -16'sd32768, -8'sd1, 8'h00, 8'h00, 1'b0, 1'b1);

    // Back-to-back: second start presented in the done cycle.
    directed("-50/-3 b2b", -16'sd50, -8'sd3, 8'd16, 8'hFE, 1'b0, 1'b0);

    // start held high and operands changed while busy.
    @(negedge clk);
    dividend = -16'sd100;
    divisor  = 8'sd7;
    start    = 1'b1;
    repeat (6) begin
      @(negedge clk);
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
    end
    start = 1'b0;
    wait_done(lat);
    chk("held start latency", 32'(lat), 32'd5);
    chk("held start quotient", 32'(quotient), 32'hF2);
    chk("held start remainder", 32'(remainder), 32'hFE);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    launch(16'sd100, 8'sd7);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset quotient", 32'(quotient), 32'd0);
    chk("async reset remainder", 32'(remainder), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset flags", 32'({done, dbz, ovf}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no done after reset", 32'(seen), 32'd0);
    directed("after reset 100/7", 16'sd100, 8'sd7, 8'd14, 8'd2, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      mode = int'($urandom_range(0, 4));
      if (mode == 0) begin
        a = 16'($urandom);
        b = 8'($urandom);
      end else if (mode == 1) begin
        a = 16'($urandom);
        b = 8'sd0;
      end else begin
        b = 8'($urandom);
        if (b == 0) b = 8'sd1;
        bi = int'(b);
        qi = int'($urandom_range(0, 255)) - 128;
        ri = int'($urandom_range(0, ((bi < 0) ? -bi : bi) - 1));
        if (qi * bi < 0) ri = -ri;
        a = 16'(qi * bi + ri);
      end
      launch(a, b);
      wait_done(lat);
      chk("random latency", 32'(lat), 32'd10);
      if ($urandom_range(0, 2) != 0) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
